rpn_stack_calc: RTL and testbench

RPN_STACK_CALC -- requirements
Module: rpn_stack_calc

---
 rtl/rpn_stack_calc.sv | 174 +++++++++++++++++
 tb/tb_rpn_stack_calc.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/rpn_stack_calc.sv
// Reverse-Polish stack calculator: button-driven push/execute on a DEPTH-entry
// operand stack with a two-state READY/ERROR controller and ALU status flags.
module rpn_stack_calc #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           Push,
    input  logic                           Exec,
    input  logic                           Clear,
    input  logic [2:0]                     OpCode,
    input  logic [WIDTH-1:0]               DataIn,
    output logic [WIDTH-1:0]               ToDisplay,
    output logic [4:0]                     Flags,
    output logic [2:0]                     Status,
    output logic [$clog2(DEPTH+1)-1:0]     Depth
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_DUP  = 3'b101;
    localparam logic [2:0] OP_DROP = 3'b110;
    localparam logic [2:0] OP_SWAP = 3'b111;

    typedef enum logic {READY = 1'b0, ERROR = 1'b1} state_t;

    // Returns {V, C, result}; operands are second (a) and top (b).
    function automatic logic [WIDTH+1:0] alu(input logic [2:0] op,
                                             input logic signed [WIDTH-1:0] a,
                                             input logic signed [WIDTH-1:0] b);
        logic [WIDTH:0]   ext;
        logic [WIDTH-1:0] r;
        logic             v;
        logic             c;
        ext = '0;
        r   = '0;
        v   = 1'b0;
        c   = 1'b0;
        case (op)
            OP_ADD: begin
                ext = {1'b0, a} + {1'b0, b};
                r   = ext[WIDTH-1:0];
                c   = ext[WIDTH];
                v   = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                // The extra MSB of a widened subtraction is the unsigned borrow.
                ext = {1'b0, a} - {1'b0, b};
                r   = ext[WIDTH-1:0];
                c   = ext[WIDTH];
                v   = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            default: r = a ^ b;
        endcase
        return {v, c, r};
    endfunction

    logic                    push_p0, push_p1, exec_p0, exec_p1;
    logic                    push_pulse, exec_pulse;
    state_t                  state;
    logic [DW-1:0]           depth_r;
    logic [WIDTH-1:0]        stack [DEPTH];
    logic                    flag_v, flag_c, flag_z, flag_n;
    logic [AW-1:0]           top_idx, sec_idx, push_idx;
    logic                    has1, has2, full;
    logic signed [WIDTH-1:0] opnd_a, opnd_b;
    logic [WIDTH+1:0]        alu_out;
    logic [WIDTH-1:0]        alu_res;

    assign push_pulse = push_p0 & ~push_p1;
    assign exec_pulse = exec_p0 & ~exec_p1;

    assign top_idx  = AW'(depth_r - DW'(1));
    assign sec_idx  = AW'(depth_r - DW'(2));
    assign push_idx = AW'(depth_r);
    assign has1     = (depth_r != '0);
    assign has2     = (depth_r >= DW'(2));
    assign full     = (depth_r == DW'(DEPTH));

    assign opnd_a  = stack[sec_idx];
    assign opnd_b  = stack[top_idx];
    assign alu_out = alu(OpCode, opnd_a, opnd_b);
    assign alu_res = alu_out[WIDTH-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            push_p0 <= 1'b0;
            push_p1 <= 1'b0;
            exec_p0 <= 1'b0;
            exec_p1 <= 1'b0;
            state   <= READY;
            depth_r <= '0;
            flag_v  <= 1'b0;
            flag_c  <= 1'b0;
            flag_z  <= 1'b0;
            flag_n  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) stack[i] <= '0;
        end else begin
            // p0: button sample, p1: previous sample for edge detection
            push_p0 <= Push;
            push_p1 <= push_p0;
            exec_p0 <= Exec;
            exec_p1 <= exec_p0;

            if (Clear) begin
                state   <= READY;
                depth_r <= '0;
                flag_v  <= 1'b0;
                flag_c  <= 1'b0;
                flag_z  <= 1'b0;
                flag_n  <= 1'b0;
            end else if (state == READY) begin
                if (exec_pulse) begin
                    case (OpCode)
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                            if (!has2) begin
                                state <= ERROR;
                            end else begin
                                stack[sec_idx] <= alu_res;
                                depth_r        <= depth_r - DW'(1);
                                flag_v         <= alu_out[WIDTH+1];
                                flag_c         <= alu_out[WIDTH];
                                flag_z         <= (alu_res == '0);
                                flag_n         <= alu_res[WIDTH-1];
                            end
                        end
                        OP_DUP: begin
                            if (!has1 || full) begin
                                state <= ERROR;
                            end else begin
                                stack[push_idx] <= stack[top_idx];
                                depth_r         <= depth_r + DW'(1);
                            end
                        end
                        OP_DROP: begin
                            if (!has1) state <= ERROR;
                            else       depth_r <= depth_r - DW'(1);
                        end
                        default: begin
                            if (!has2) begin
                                state <= ERROR;
                            end else begin
                                stack[top_idx] <= stack[sec_idx];
                                stack[sec_idx] <= stack[top_idx];
                            end
                        end
                    endcase
                end else if (push_pulse) begin
                    if (full) begin
                        state <= ERROR;
                    end else begin
                        stack[push_idx] <= DataIn;
                        depth_r         <= depth_r + DW'(1);
                    end
                end
            end
        end
    end

    assign ToDisplay = has1 ? stack[top_idx] : DataIn;
    assign Flags     = {state == ERROR, flag_v, flag_c, flag_z, flag_n};
    assign Status    = {state == ERROR, full, ~has1};
    assign Depth     = depth_r;

endmodule

// File: tb/tb_rpn_stack_calc.sv
// Randomized bench for rpn_stack_calc with a queue-based reference model of the
// calculator's behaviour at button-press granularity.
module tb_rpn_stack_calc;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        Push = 1'b0;
    logic        Exec = 1'b0;
    logic        Clear = 1'b0;
    logic [2:0]  OpCode = 3'b000;
    logic [15:0] DataIn = 16'h0000;
    logic [15:0] ToDisplay;
    logic [4:0]  Flags;
    logic [2:0]  Status;
    logic [2:0]  Depth;

    int n_checks = 0;
    int n_fails  = 0;

    int   m_q[$];
    logic m_err, m_v, m_c, m_z, m_n;

    rpn_stack_calc #(.WIDTH(16), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .Push(Push), .Exec(Exec), .Clear(Clear),
        .OpCode(OpCode), .DataIn(DataIn), .ToDisplay(ToDisplay),
        .Flags(Flags), .Status(Status), .Depth(Depth)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int sx16(input int x);
        return (x >= 32768) ? x - 65536 : x;
    endfunction

    task automatic model_clear();
        m_q.delete();
        m_err = 1'b0;
        m_v = 1'b0; m_c = 1'b0; m_z = 1'b0; m_n = 1'b0;
    endtask

    task automatic model_step(input logic p, input logic e, input logic [2:0] op,
                              input logic [15:0] d, input logic clr);
        int a, b, r, sr;
        if (clr) begin
            model_clear();
        end else if (!m_err) begin
            if (e) begin
                if (op <= 3'd4) begin
                    if (m_q.size() < 2) m_err = 1'b1;
                    else begin
                        b = m_q.pop_back();
                        a = m_q.pop_back();
                        m_v = 1'b0; m_c = 1'b0; r = 0;
                        case (op)
                            3'd0: begin
                                r = a + b; m_c = (r > 65535);
                                sr = sx16(a) + sx16(b); m_v = (sr > 32767) || (sr < -32768);
                            end
                            3'd1: begin
                                r = a - b; m_c = (a < b);
                                sr = sx16(a) - sx16(b); m_v = (sr > 32767) || (sr < -32768);
                            end
                            3'd2: r = a & b;
                            3'd3: r = a | b;
                            default: r = a ^ b;
                        endcase
                        r = r & 32'hFFFF;
                        m_z = (r == 0);
                        m_n = ((r >> 15) & 1) == 1;
                        m_q.push_back(r);
                    end
                end else if (op == 3'd5) begin
                    if (m_q.size() == 0 || m_q.size() == 4) m_err = 1'b1;
                    else m_q.push_back(m_q[$]);
                end else if (op == 3'd6) begin
                    if (m_q.size() == 0) m_err = 1'b1;
                    else void'(m_q.pop_back());
                end else begin
                    if (m_q.size() < 2) m_err = 1'b1;
                    else begin
                        b = m_q.pop_back();
                        a = m_q.pop_back();
                        m_q.push_back(b);
                        m_q.push_back(a);
                    end
                end
            end else if (p) begin
                if (m_q.size() == 4) m_err = 1'b1;
                else m_q.push_back(int'(d));
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [15:0] exp_disp;
        exp_disp = (m_q.size() == 0) ? DataIn : 16'(m_q[$]);
        check_eq({tag, ".depth"}, 32'(Depth), 32'(m_q.size()));
        check_eq({tag, ".disp"}, 32'(ToDisplay), 32'(exp_disp));
        check_eq({tag, ".flags"}, 32'(Flags), 32'({m_err, m_v, m_c, m_z, m_n}));
        check_eq({tag, ".status"}, 32'(Status),
                 32'({m_err, m_q.size() == 4, m_q.size() == 0}));
    endtask

    // One button action: inputs held across the detection and update edges,
    // released, checked, then a low sample so the next press is a fresh edge.
    task automatic step(input logic p, input logic e, input logic [2:0] op,
                        input logic [15:0] d, input logic clr, input string tag);
        @(negedge clk);
        Push = p; Exec = e; OpCode = op; DataIn = d; Clear = clr;
        repeat (2) @(posedge clk);
        @(negedge clk);
        Push = 1'b0; Exec = 1'b0; Clear = 1'b0;
        model_step(p, e, op, d, clr);
        check_all(tag);
        @(posedge clk);
    endtask

    initial begin
        model_clear();
        #1;
        check_all("reset");
        #12;
        @(negedge clk);
        reset = 1'b1;

        step(1, 0, 3'd0, 16'h0005, 0, "sub_p1");
        step(1, 0, 3'd0, 16'h0003, 0, "sub_p2");
        step(0, 1, 3'd1, 16'h0000, 0, "sub_ex");
        check_eq("sub_result", 32'(ToDisplay), 32'h2);

        step(0, 0, 3'd0, 16'h0000, 1, "clr1");
        step(1, 0, 3'd0, 16'h7FFF, 0, "ovf_p1");
        step(1, 0, 3'd0, 16'h0001, 0, "ovf_p2");
        step(0, 1, 3'd0, 16'h0000, 0, "ovf_add");
        check_eq("ovf_flags", 32'(Flags), 32'b01001);

        step(0, 0, 3'd0, 16'h0000, 1, "clr2");
        for (int i = 0; i < 5; i++) step(1, 0, 3'd0, 16'(16'h0100 + i), 0, "five_push");
        check_eq("five_status", 32'(Status), 32'b110);
        check_eq("five_top", 32'(ToDisplay), 32'h0103);
        step(0, 0, 3'd0, 16'h0000, 1, "five_clr");
        check_eq("five_clr_status", 32'(Status), 32'b001);

        step(1, 0, 3'd0, 16'h00AA, 0, "swap_p");
        step(0, 1, 3'd7, 16'h0000, 0, "swap_err");
        check_eq("swap_err_top", 32'(ToDisplay), 32'h00AA);
        step(0, 0, 3'd0, 16'h0000, 1, "swap_clr");

        step(1, 0, 3'd0, 16'h1234, 0, "dup_p");
        step(1, 1, 3'd5, 16'h5555, 0, "dup_both");
        step(0, 1, 3'd6, 16'h5555, 0, "dup_drop");
        check_eq("dup_second", 32'(ToDisplay), 32'h1234);
        step(0, 0, 3'd0, 16'h0000, 1, "clr3");

        // Held button: one pulse, then an asynchronous reset mid-hold
        @(negedge clk);
        Push = 1'b1; DataIn = 16'hBEEF;
        repeat (10) @(posedge clk);
        #1;
        model_step(1, 0, 3'd0, 16'hBEEF, 0);
        check_all("hold");
        #1 reset = 1'b0;
        #1;
        model_clear();
        check_all("hold_rst");
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        model_step(1, 0, 3'd0, 16'hBEEF, 0);
        check_all("rst_release_high");
        @(negedge clk);
        Push = 1'b0;
        @(posedge clk);

        for (int i = 0; i < 400; i++) begin
            logic        rp, re, rc;
            logic [2:0]  rop;
            logic [15:0] rd;
            rc  = ($urandom_range(0, 19) == 0);
            rp  = ($urandom_range(0, 1) == 1);
            re  = ($urandom_range(0, 2) != 0);
            rop = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0:       rd = 16'h7FFF;
                1:       rd = 16'h8000;
                default: rd = 16'($urandom);
            endcase
            if (m_err && $urandom_range(0, 2) == 0) rc = 1'b1;
            step(rp, re, rop, rd, rc, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
